// File: rtl/cpu_control_sequencer.sv
// Multi-cycle fetch/decode/execute control FSM for the 16-bit accumulator CPU.
// Drives the shared control_signals strobe bus. All outputs decode
// combinationally from the state register; C6 and C0 are additionally gated
// by mem_ready. The datapath samples the strobes on the posedge that ends a state.
//
// Memory handshake: in a memory state (F2, RD, WR2) the request strobe is held
// every cycle. mem_ready high means the transfer completes on the next posedge,
// and the FSM leaves the state on that same edge. A wait counter bounds the
// stall. If the counter equals MEM_WAIT_MAX and mem_ready is still low, the FSM
// faults. A mem_ready that arrives on the limiting cycle still completes normally.
//
// state_o encoding: IDLE=0 F1=1 F2=2 F3=3 DEC=4 RD=5 BRL=6 EX=7 WR1=8 WR2=9
//                   JP=10 HLT=11 FLT=12
module cpu_control_sequencer #(
    parameter int OPC_W        = 8,
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [OPC_W-1:0] ir_opcode,
    input  logic             acc_sign,
    input  logic             mem_ready,
    output logic [15:0]      control_signals,
    output logic [3:0]       state_o,
    output logic             halted,
    output logic             fault
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_F1   = 4'd1,
        S_F2   = 4'd2,
        S_F3   = 4'd3,
        S_DEC  = 4'd4,
        S_RD   = 4'd5,
        S_BRL  = 4'd6,
        S_EX   = 4'd7,
        S_WR1  = 4'd8,
        S_WR2  = 4'd9,
        S_JP   = 4'd10,
        S_HLT  = 4'd11,
        S_FLT  = 4'd12
    } state_t;

    // Strobe bit positions on control_signals
    localparam int C_PC_INC   = 0;
    localparam int C_PC_LOAD  = 1;
    localparam int C_MAR_PC   = 2;
    localparam int C_MAR_MBR  = 3;
    localparam int C_MEM_RD   = 4;
    localparam int C_MEM_WR   = 5;
    localparam int C_MBR_MEM  = 6;
    localparam int C_MBR_ACC  = 7;
    localparam int C_BR_MBR   = 8;
    localparam int C_IR_MBR   = 9;
    localparam int C_ACC_CLR  = 10;
    localparam int C_ALU_ADD  = 11;
    localparam int C_ALU_SUB  = 12;
    localparam int C_ACC_ALU  = 13;
    localparam int C_HALT     = 15;

    localparam logic [OPC_W-1:0] OP_STORE  = OPC_W'(1);
    localparam logic [OPC_W-1:0] OP_LOAD   = OPC_W'(2);
    localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(3);
    localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(4);
    localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(5);
    localparam logic [OPC_W-1:0] OP_JMPGEZ = OPC_W'(6);
    localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(7);

    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_wait_cnt;
    logic [OPC_W-1:0] r_opcode;
    logic [15:0]      w_ctrl;
    logic             w_in_wait;
    logic             w_timeout;

    assign w_in_wait = (r_state == S_F2) || (r_state == S_RD) || (r_state == S_WR2);
    assign w_timeout = (r_wait_cnt == WAIT_MAX);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Opcode latch: the EX state uses the opcode seen in DEC, not the live input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_opcode <= '0;
        end else if (r_state == S_DEC) begin
            r_opcode <= ir_opcode;
        end
    end

    // Wait counter: held at zero outside memory states, so it is clear on entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!w_in_wait) begin
            r_wait_cnt <= '0;
        end else if (!mem_ready && !w_timeout) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = S_F1;
            end
            S_F1: begin
                w_ctrl[C_MAR_PC] = 1'b1;
                w_next           = S_F2;
            end
            S_F2: begin
                w_ctrl[C_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    w_ctrl[C_MBR_MEM] = 1'b1;
                    w_ctrl[C_PC_INC]  = 1'b1;
                    w_next            = S_F3;
                end else if (w_timeout) begin
                    w_next = S_FLT;
                end
            end
            S_F3: begin
                w_ctrl[C_IR_MBR]  = 1'b1;
                w_ctrl[C_MAR_MBR] = 1'b1;
                w_next            = S_DEC;
            end
            S_DEC: begin
                case (ir_opcode)
                    OP_LOAD, OP_ADD, OP_SUB: w_next = S_RD;
                    OP_STORE:                w_next = S_WR1;
                    OP_JMP:                  w_next = S_JP;
                    OP_JMPGEZ:               w_next = acc_sign ? S_F1 : S_JP;
                    OP_HALT:                 w_next = S_HLT;
                    default:                 w_next = S_FLT;
                endcase
            end
            S_RD: begin
                w_ctrl[C_MEM_RD] = 1'b1;
                if (mem_ready) begin
                    w_ctrl[C_MBR_MEM] = 1'b1;
                    w_next            = S_BRL;
                end else if (w_timeout) begin
                    w_next = S_FLT;
                end
            end
            S_BRL: begin
                w_ctrl[C_BR_MBR] = 1'b1;
                w_next           = S_EX;
            end
            S_EX: begin
                // LOAD is ACC <- 0 + BR, so it clears ACC and adds through the ALU
                case (r_opcode)
                    OP_LOAD: begin
                        w_ctrl[C_ACC_CLR] = 1'b1;
                        w_ctrl[C_ALU_ADD] = 1'b1;
                        w_ctrl[C_ACC_ALU] = 1'b1;
                    end
                    OP_ADD: begin
                        w_ctrl[C_ALU_ADD] = 1'b1;
                        w_ctrl[C_ACC_ALU] = 1'b1;
                    end
                    OP_SUB: begin
                        w_ctrl[C_ALU_SUB] = 1'b1;
                        w_ctrl[C_ACC_ALU] = 1'b1;
                    end
                    default: ;
                endcase
                w_next = S_F1;
            end
            S_WR1: begin
                w_ctrl[C_MBR_ACC] = 1'b1;
                w_next            = S_WR2;
            end
            S_WR2: begin
                w_ctrl[C_MEM_WR] = 1'b1;
                if (mem_ready) begin
                    w_next = S_F1;
                end else if (w_timeout) begin
                    w_next = S_FLT;
                end
            end
            S_JP: begin
                w_ctrl[C_PC_LOAD] = 1'b1;
                w_next            = S_F1;
            end
            S_HLT: begin
                w_ctrl[C_HALT] = 1'b1;
            end
            S_FLT: begin
                w_next = S_FLT;
            end
            default: begin
                w_next = S_FLT;
            end
        endcase
    end

    assign control_signals = w_ctrl;
    assign state_o         = r_state;
    assign halted          = (r_state == S_HLT);
    assign fault           = (r_state == S_FLT);

endmodule
